// File: rtl/elevator_pkg.sv
// Shared elevator-side constants, state encoding and slot helpers.
package elevator_pkg;

    localparam int unsigned FLOOR_W    = 3;
    localparam int unsigned NUM_FLOORS = 8;
    localparam int unsigned SLOT_W     = 4;
    localparam int unsigned NUM_SLOTS  = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] ELEV_1 = 2'b01;
    localparam logic [1:0] ELEV_2 = 2'b10;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        SETTLE = 2'd1,
        OFFER  = 2'd2
    } hall_q_state_t;

    // Up calls occupy slots 0-7, down calls slots 8-15.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [FLOOR_W-1:0] floor,
                                                  input logic dir);
        return {~dir, floor};
    endfunction

endpackage

// File: rtl/hall_call_picker.sv
// Round-robin find-first over the eligible slot mask, starting at rr_ptr.
module hall_call_picker
    import elevator_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] eligible,
    input  logic [SLOT_W-1:0]    rr_ptr,
    output logic                 found,
    output logic [SLOT_W-1:0]    idx
);

    // Walk from the far end back toward rr_ptr so the closest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (eligible[SLOT_W'(rr_ptr + SLOT_W'(i))]) begin
                found = 1'b1;
                idx   = SLOT_W'(rr_ptr + SLOT_W'(i));
            end
        end
    end

endmodule

// File: rtl/hall_call_queue.sv
// Hall call latch and single-call feeder for building_dispatcher, with a
// valid/ready assignment hand-off to the elevator side.
module hall_call_queue
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_up_btn,
    input  logic [NUM_FLOORS-1:0] hall_down_btn,
    input  logic                  arrive_valid_elev_1,
    input  logic                  arrive_valid_elev_2,
    input  logic [FLOOR_W-1:0]    arrive_floor_elev_1,
    input  logic [FLOOR_W-1:0]    arrive_floor_elev_2,
    input  logic                  arrive_dir_elev_1,
    input  logic                  arrive_dir_elev_2,
    output logic [FLOOR_W-1:0]    request_floor,
    output logic                  request_dir,
    input  logic [1:0]            dispatch_elev,
    output logic                  assign_valid,
    input  logic                  assign_ready,
    output logic [1:0]            assign_elev,
    output logic [FLOOR_W-1:0]    assign_floor,
    output logic                  assign_dir,
    output logic [NUM_FLOORS-1:0] hall_up_lamp,
    output logic [NUM_FLOORS-1:0] hall_down_lamp
);

    hall_q_state_t         state;
    hall_q_state_t         state_next;
    logic [NUM_SLOTS-1:0]  pending;
    logic [NUM_SLOTS-1:0]  assigned;
    logic [NUM_SLOTS-1:0]  set_mask;
    logic [NUM_SLOTS-1:0]  clr_mask;
    logic [NUM_SLOTS-1:0]  hs_mask;
    logic [NUM_SLOTS-1:0]  eligible;
    logic [SLOT_W-1:0]     rr_ptr;
    logic [SLOT_W-1:0]     slot;
    logic [SLOT_W-1:0]     pick_idx;
    logic                  pick_found;
    logic                  handshake;
    logic                  slot_cleared;

    // Top up-button and bottom down-button do not exist; mask them off.
    always_comb begin
        set_mask = {hall_down_btn & 8'hFE, hall_up_btn & 8'h7F};
        clr_mask = '0;
        if (arrive_valid_elev_1) begin
            clr_mask[slot_of(arrive_floor_elev_1, arrive_dir_elev_1)] = 1'b1;
        end
        if (arrive_valid_elev_2) begin
            clr_mask[slot_of(arrive_floor_elev_2, arrive_dir_elev_2)] = 1'b1;
        end
    end

    assign eligible     = pending & ~assigned;
    assign handshake    = (state == OFFER) && assign_valid && assign_ready;
    assign slot_cleared = clr_mask[slot];
    assign hs_mask      = handshake ? (NUM_SLOTS'(1) << slot) : '0;

    assign hall_up_lamp   = pending[NUM_FLOORS-1:0];
    assign hall_down_lamp = pending[NUM_SLOTS-1:NUM_FLOORS];

    hall_call_picker u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Next-state: a clear of the in-flight slot withdraws it unless it hands off.
    always_comb begin
        state_next = state;
        case (state)
            SCAN: begin
                if (pick_found) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                state_next = slot_cleared ? SCAN : OFFER;
            end
            OFFER: begin
                if (handshake || slot_cleared) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // State register, slot bits and registered request/assignment outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SCAN;
            pending       <= '0;
            assigned      <= '0;
            rr_ptr        <= '0;
            slot          <= '0;
            request_floor <= '0;
            request_dir   <= 1'b0;
            assign_valid  <= 1'b0;
            assign_elev   <= '0;
            assign_floor  <= '0;
            assign_dir    <= 1'b0;
        end else begin
            state    <= state_next;
            // A press beats a same-cycle clear; a clear beats a same-cycle handshake.
            pending  <= (pending & ~clr_mask) | set_mask;
            assigned <= (assigned | hs_mask) & ~clr_mask;
            case (state)
                SCAN: begin
                    if (pick_found) begin
                        slot          <= pick_idx;
                        request_floor <= pick_idx[FLOOR_W-1:0];
                        request_dir   <= pick_idx[SLOT_W-1] ? DIR_DOWN : DIR_UP;
                    end
                end
                SETTLE: begin
                    if (!slot_cleared) begin
                        assign_elev  <= (dispatch_elev == ELEV_2) ? ELEV_2 : ELEV_1;
                        assign_floor <= request_floor;
                        assign_dir   <= request_dir;
                        assign_valid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (handshake) begin
                        assign_valid <= 1'b0;
                        rr_ptr       <= slot + SLOT_W'(1);
                    end else if (slot_cleared) begin
                        assign_valid <= 1'b0;
                    end
                end
                default: begin
                    assign_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hall_call_queue.sv
// Directed bench for hall_call_queue with a scoreboard of expected assignments.
module tb_hall_call_queue;

    typedef struct packed {
        logic [1:0] elev;
        logic [2:0] floor;
        logic       dir;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] hall_up_btn;
    logic [7:0] hall_down_btn;
    logic       arrive_valid_elev_1;
    logic       arrive_valid_elev_2;
    logic [2:0] arrive_floor_elev_1;
    logic [2:0] arrive_floor_elev_2;
    logic       arrive_dir_elev_1;
    logic       arrive_dir_elev_2;
    logic [2:0] request_floor;
    logic       request_dir;
    logic [1:0] dispatch_elev;
    logic       assign_valid;
    logic       assign_ready;
    logic [1:0] assign_elev;
    logic [2:0] assign_floor;
    logic       assign_dir;
    logic [7:0] hall_up_lamp;
    logic [7:0] hall_down_lamp;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    hall_call_queue dut (
        .clk                 (clk),
        .rst                 (rst),
        .hall_up_btn         (hall_up_btn),
        .hall_down_btn       (hall_down_btn),
        .arrive_valid_elev_1 (arrive_valid_elev_1),
        .arrive_valid_elev_2 (arrive_valid_elev_2),
        .arrive_floor_elev_1 (arrive_floor_elev_1),
        .arrive_floor_elev_2 (arrive_floor_elev_2),
        .arrive_dir_elev_1   (arrive_dir_elev_1),
        .arrive_dir_elev_2   (arrive_dir_elev_2),
        .request_floor       (request_floor),
        .request_dir         (request_dir),
        .dispatch_elev       (dispatch_elev),
        .assign_valid        (assign_valid),
        .assign_ready        (assign_ready),
        .assign_elev         (assign_elev),
        .assign_floor        (assign_floor),
        .assign_dir          (assign_dir),
        .hall_up_lamp        (hall_up_lamp),
        .hall_down_lamp      (hall_down_lamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] payload();
        return 32'({assign_valid, assign_elev, assign_floor, assign_dir});
    endfunction

    // Scoreboard: every accepted assignment must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && assign_valid && assign_ready) begin
            exp_t e;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_assign observed=%0h expected=none",
                       {assign_elev, assign_floor, assign_dir});
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_elev",  32'(assign_elev),  32'(e.elev));
                check("sb_floor", 32'(assign_floor), 32'(e.floor));
                check("sb_dir",   32'(assign_dir),   32'(e.dir));
            end
        end
    end

    initial begin
        rst = 1'b1;
        hall_up_btn = '0;
        hall_down_btn = '0;
        arrive_valid_elev_1 = 1'b0;
        arrive_valid_elev_2 = 1'b0;
        arrive_floor_elev_1 = '0;
        arrive_floor_elev_2 = '0;
        arrive_dir_elev_1 = 1'b0;
        arrive_dir_elev_2 = 1'b0;
        dispatch_elev = '0;
        assign_ready = 1'b0;
        tick();
        tick();
        check("rst_payload", payload(), 32'h0);
        check("rst_req", 32'({request_floor, request_dir}), 32'h0);
        check("rst_lamps", 32'({hall_up_lamp, hall_down_lamp}), 32'h0);
        rst = 1'b0;

        // Single call
        dispatch_elev = 2'b10;
        assign_ready = 1'b1;
        sb.push_back(exp_t'({2'b10, 3'd2, 1'b1}));
        hall_up_btn = 8'h04;
        tick();
        hall_up_btn = '0;
        check("t1_lamp", 32'(hall_up_lamp), 32'h04);
        check("t1_valid0", 32'(assign_valid), 32'h0);
        tick();
        check("t1_req", 32'({request_floor, request_dir}), 32'({3'd2, 1'b1}));
        check("t1_valid1", 32'(assign_valid), 32'h0);
        tick();
        check("t1_offer", payload(), 32'({1'b1, 2'b10, 3'd2, 1'b1}));
        tick();
        check("t1_drop", 32'(assign_valid), 32'h0);
        tick();
        tick();
        check("t1_lamp_held", 32'(hall_up_lamp), 32'h04);
        check("t1_no_reoffer", 32'(assign_valid), 32'h0);
        arrive_valid_elev_2 = 1'b1;
        arrive_floor_elev_2 = 3'd2;
        arrive_dir_elev_2 = 1'b1;
        tick();
        arrive_valid_elev_2 = 1'b0;
        check("t1_clear", 32'(hall_up_lamp), 32'h0);

        // Round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dispatch_elev = 2'b01;
        sb.push_back(exp_t'({2'b01, 3'd1, 1'b1}));
        sb.push_back(exp_t'({2'b01, 3'd5, 1'b1}));
        sb.push_back(exp_t'({2'b01, 3'd3, 1'b0}));
        hall_up_btn = 8'h22;
        hall_down_btn = 8'h08;
        tick();
        hall_up_btn = '0;
        hall_down_btn = '0;
        check("t2_lamps", 32'({hall_up_lamp, hall_down_lamp}), 32'h2208);
        for (int k = 2; k <= 12; k++) begin
            tick();
            check("t2_valid", 32'(assign_valid), 32'((k % 3 == 0) && (k <= 9)));
        end
        arrive_valid_elev_1 = 1'b1;
        arrive_floor_elev_1 = 3'd1;
        arrive_dir_elev_1 = 1'b1;
        arrive_valid_elev_2 = 1'b1;
        arrive_floor_elev_2 = 3'd5;
        arrive_dir_elev_2 = 1'b1;
        tick();
        arrive_valid_elev_2 = 1'b0;
        arrive_floor_elev_1 = 3'd3;
        arrive_dir_elev_1 = 1'b0;
        check("t2_dual_clear", 32'({hall_up_lamp, hall_down_lamp}), 32'h0008);
        tick();
        arrive_valid_elev_1 = 1'b0;
        check("t2_down_clear", 32'(hall_down_lamp), 32'h0);

        // Backpressure then withdrawal
        dispatch_elev = 2'b10;
        assign_ready = 1'b0;
        hall_down_btn = 8'h40;
        tick();
        hall_down_btn = '0;
        tick();
        tick();
        check("t3_offer", payload(), 32'({1'b1, 2'b10, 3'd6, 1'b0}));
        dispatch_elev = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_stable", payload(), 32'({1'b1, 2'b10, 3'd6, 1'b0}));
        end
        arrive_valid_elev_1 = 1'b1;
        arrive_floor_elev_1 = 3'd6;
        arrive_dir_elev_1 = 1'b0;
        tick();
        arrive_valid_elev_1 = 1'b0;
        check("t3_withdraw", 32'(assign_valid), 32'h0);
        check("t3_lamp", 32'(hall_down_lamp), 32'h0);
        assign_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_idle", 32'(assign_valid), 32'h0);
        end

        // Ignored buttons
        hall_up_btn = 8'h80;
        hall_down_btn = 8'h01;
        tick();
        hall_up_btn = '0;
        hall_down_btn = '0;
        check("t4_no_lamp", 32'({hall_up_lamp, hall_down_lamp}), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_no_valid", 32'(assign_valid), 32'h0);
            check("t4_req_hold", 32'({request_floor, request_dir}), 32'({3'd6, 1'b0}));
        end

        // Re-press of an assigned pending slot
        sb.push_back(exp_t'({2'b01, 3'd4, 1'b1}));
        hall_up_btn = 8'h10;
        tick();
        hall_up_btn = '0;
        tick();
        tick();
        check("t4_offer", payload(), 32'({1'b1, 2'b01, 3'd4, 1'b1}));
        tick();
        check("t4_drop", 32'(assign_valid), 32'h0);
        hall_up_btn = 8'h10;
        tick();
        hall_up_btn = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_no_second", 32'(assign_valid), 32'h0);
        end
        check("t4_lamp", 32'(hall_up_lamp), 32'h10);

        // Press and clear together re-arms the slot
        sb.push_back(exp_t'({2'b01, 3'd4, 1'b1}));
        hall_up_btn = 8'h10;
        arrive_valid_elev_1 = 1'b1;
        arrive_floor_elev_1 = 3'd4;
        arrive_dir_elev_1 = 1'b1;
        tick();
        hall_up_btn = '0;
        arrive_valid_elev_1 = 1'b0;
        check("t4_press_wins", 32'(hall_up_lamp), 32'h10);
        tick();
        tick();
        check("t4_reoffer", payload(), 32'({1'b1, 2'b01, 3'd4, 1'b1}));
        tick();
        check("t4_sb_empty", 32'(sb.size()), 32'h0);
        arrive_valid_elev_2 = 1'b1;
        arrive_floor_elev_2 = 3'd4;
        arrive_dir_elev_2 = 1'b1;
        tick();
        arrive_valid_elev_2 = 1'b0;
        check("t4_clear", 32'(hall_up_lamp), 32'h0);

        // Invalid dispatch code, then reset during OFFER
        dispatch_elev = 2'b11;
        assign_ready = 1'b0;
        hall_down_btn = 8'h20;
        tick();
        hall_down_btn = '0;
        tick();
        tick();
        check("t5_elev_map", payload(), 32'({1'b1, 2'b01, 3'd5, 1'b0}));
        check("t5_lamp", 32'(hall_down_lamp), 32'h20);
        rst = 1'b1;
        tick();
        check("t5_rst_payload", payload(), 32'h0);
        check("t5_rst_req", 32'({request_floor, request_dir}), 32'h0);
        check("t5_rst_lamps", 32'({hall_up_lamp, hall_down_lamp}), 32'h0);
        rst = 1'b0;
        assign_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t5_post_rst", 32'(assign_valid), 32'h0);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
